sprite_bouncer: RTL and testbench

SPRITE_BOUNCER -- requirements
Module: sprite_bouncer

---
 rtl/vga_pkg.sv | 18 +
 rtl/bounce_axis.sv | 79 +++++++
 rtl/sprite_bouncer.sv | 140 ++++++++++++++
 tb/tb_sprite_bouncer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants, the RGB444 to RGB888 expansion and the axis direction type.
package vga_pkg;

    localparam int SCR_W_DEF = 640;
    localparam int SCR_H_DEF = 480;

    // Direction of travel on one axis; 1 means the coordinate is increasing.
    typedef enum logic {
        DIR_DEC = 1'b0,
        DIR_INC = 1'b1
    } dir_e;

    // Widen each 4-bit channel to 8 bits by placing it in the upper nibble.
    function automatic logic [23:0] rgb444_to_888(input logic [11:0] c);
        return {c[11:8], 4'h0, c[7:4], 4'h0, c[3:0], 4'h0};
    endfunction

endpackage

// File: rtl/bounce_axis.sv
// One axis of sprite motion: position, direction state, clamping at the walls.
// hit reports that the pending move reflects off a wall; the top qualifies it
// with the update tick.
module bounce_axis
    import vga_pkg::*;
#(
    parameter int MAXP = 540,
    parameter int STEP = 1
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       tick,
    output logic [9:0] pos,
    output logic       hit
);

    localparam logic [10:0] MAX11  = 11'(MAXP);
    localparam logic [10:0] STEP11 = 11'(STEP);

    dir_e       dir_r;
    dir_e       nxt_dir_s;
    logic [9:0] pos_r;
    logic [9:0] nxt_pos_s;
    logic       hit_s;

    // Next position/direction assuming a tick; clamps to [0, MAXP] and flags reflections.
    always_comb begin
        nxt_pos_s = pos_r;
        nxt_dir_s = dir_r;
        hit_s     = 1'b0;
        if (MAX11 == 11'd0) begin
            // Sprite as wide as the screen: pinned at 0, never reflects.
            nxt_pos_s = 10'd0;
        end else begin
            case (dir_r)
                DIR_INC: begin
                    if (({1'b0, pos_r} + STEP11) >= MAX11) begin
                        nxt_pos_s = MAX11[9:0];
                        nxt_dir_s = DIR_DEC;
                        hit_s     = 1'b1;
                    end else begin
                        nxt_pos_s = pos_r + STEP11[9:0];
                    end
                end
                DIR_DEC: begin
                    if ({1'b0, pos_r} <= STEP11) begin
                        nxt_pos_s = 10'd0;
                        nxt_dir_s = DIR_INC;
                        hit_s     = 1'b1;
                    end else begin
                        nxt_pos_s = pos_r - STEP11[9:0];
                    end
                end
                default: begin
                    nxt_pos_s = 10'd0;
                    nxt_dir_s = DIR_INC;
                end
            endcase
        end
    end

    // Axis state machine: commit the move on each update tick.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            pos_r <= 10'd0;
            dir_r <= DIR_INC;
        end else if (tick) begin
            pos_r <= nxt_pos_s;
            dir_r <= nxt_dir_s;
        end else begin
            pos_r <= pos_r;
            dir_r <= dir_r;
        end
    end

    assign pos = pos_r;
    assign hit = hit_s;

endmodule

// File: rtl/sprite_bouncer.sv
// Bouncing sprite overlay for a VGA pipeline: motion divider, two bounce_axis
// instances, reflection counter and a two-stage pixel path into the sprite ROM.
// Optional feature: define SPRITE_BOUNCER_COLORKEY_EN to blank pixels equal to KEY.
module sprite_bouncer
    import vga_pkg::*;
#(
    parameter int SCR_W = SCR_W_DEF,
    parameter int SCR_H = SCR_H_DEF,
    parameter int SPR_W = 100,
    parameter int SPR_H = 100,
    parameter int STEP  = 1,
    parameter int DIV   = 250000
`ifdef SPRITE_BOUNCER_COLORKEY_EN
    ,
    parameter logic [11:0] KEY = 12'hF0F
`endif
) (
    input  logic                                 clk,
    input  logic                                 clrn,
    input  logic                                 run,
    input  logic [9:0]                           h_addr,
    input  logic [9:0]                           v_addr,
    input  logic [11:0]                          q,
    output logic [$clog2(SPR_W*SPR_H > 1 ? SPR_W*SPR_H : 2)-1:0] rom_addr,
    output logic [23:0]                          vga_data,
    output logic [9:0]                           ph_addr,
    output logic [9:0]                           pv_addr,
    output logic [15:0]                          bounce_cnt
);

    localparam int AW = $clog2(SPR_W*SPR_H > 1 ? SPR_W*SPR_H : 2);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [10:0]   SPR_W11  = 11'(SPR_W);
    localparam logic [10:0]   SPR_H11  = 11'(SPR_H);
    localparam logic [19:0]   SPR_W20  = 20'(SPR_W);

    logic [CW-1:0] div_r;
    logic          tick_s;
    logic          hit_x_s;
    logic          hit_y_s;
    logic [15:0]   bounce_r;
    logic          in_win_s;
    logic [19:0]   offset_s;
    logic [AW-1:0] rom_addr_r;
    logic          win_d1_r;
    logic [23:0]   vga_r;
    logic          key_hit_s;

    assign tick_s = run && (div_r == DIV_LAST);

    // Update-rate divider; frozen while run is low so a pause resumes mid-period.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            div_r <= {CW{1'b0}};
        end else if (run) begin
            div_r <= tick_s ? {CW{1'b0}} : div_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            div_r <= div_r;
        end
    end

    bounce_axis #(.MAXP(SCR_W - SPR_W), .STEP(STEP)) u_axis_x (
        .clk  (clk),
        .clrn (clrn),
        .tick (tick_s),
        .pos  (ph_addr),
        .hit  (hit_x_s)
    );

    bounce_axis #(.MAXP(SCR_H - SPR_H), .STEP(STEP)) u_axis_y (
        .clk  (clk),
        .clrn (clrn),
        .tick (tick_s),
        .pos  (pv_addr),
        .hit  (hit_y_s)
    );

    // Count ticks that reflect on either axis; a corner hit counts once.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            bounce_r <= 16'd0;
        end else if (tick_s && (hit_x_s || hit_y_s)) begin
            bounce_r <= bounce_r + 16'd1;
        end else begin
            bounce_r <= bounce_r;
        end
    end

    // Window test and ROM offset relative to the sprite's top-left corner.
    always_comb begin
        in_win_s = ({1'b0, h_addr} >= {1'b0, ph_addr}) &&
                   ({1'b0, h_addr} <  ({1'b0, ph_addr} + SPR_W11)) &&
                   ({1'b0, v_addr} >= {1'b0, pv_addr}) &&
                   ({1'b0, v_addr} <  ({1'b0, pv_addr} + SPR_H11));
        offset_s = 20'd0;
        if (in_win_s) begin
            offset_s = (20'(v_addr - pv_addr) * SPR_W20) + 20'(h_addr - ph_addr);
        end else begin
            offset_s = 20'd0;
        end
    end

    // Pixel stage 1: latch ROM address (held outside the window) and window flag.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            rom_addr_r <= {AW{1'b0}};
            win_d1_r   <= 1'b0;
        end else begin
            rom_addr_r <= in_win_s ? offset_s[AW-1:0] : rom_addr_r;
            win_d1_r   <= in_win_s;
        end
    end

    // Colour-key match on the ROM word; never matches when the feature is off.
    always_comb begin
        key_hit_s = 1'b0;
`ifdef SPRITE_BOUNCER_COLORKEY_EN
        key_hit_s = (q == KEY);
`else
        key_hit_s = 1'b0;
`endif
    end

    // Pixel stage 2: expand the ROM word inside the window, black elsewhere.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            vga_r <= 24'h000000;
        end else if (win_d1_r && !key_hit_s) begin
            vga_r <= rgb444_to_888(q);
        end else begin
            vga_r <= 24'h000000;
        end
    end

    assign rom_addr   = rom_addr_r;
    assign vga_data   = vga_r;
    assign bounce_cnt = bounce_r;

endmodule

// File: tb/tb_sprite_bouncer.sv
// Directed bench for sprite_bouncer: reset, pixel path, pause, wall edge,
// corner bounce and colour key. Three DUT instances share the stimulus.
module tb_sprite_bouncer;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        run = 1'b0;
    logic [9:0]  h_addr = 10'd700;
    logic [9:0]  v_addr = 10'd700;
    logic [11:0] q = 12'h000;

    logic [13:0] m_rom, e_rom, c_rom;
    logic [23:0] m_vga, e_vga, c_vga;
    logic [9:0]  m_ph, m_pv, e_ph, e_pv, c_ph, c_pv;
    logic [15:0] m_cnt, e_cnt, c_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sprite_bouncer #(.SCR_W(640), .SCR_H(480), .SPR_W(100), .SPR_H(100), .STEP(1), .DIV(8)) u_main (
        .clk(clk), .clrn(clrn), .run(run), .h_addr(h_addr), .v_addr(v_addr), .q(q),
        .rom_addr(m_rom), .vga_data(m_vga), .ph_addr(m_ph), .pv_addr(m_pv), .bounce_cnt(m_cnt)
    );

    sprite_bouncer #(.SCR_W(640), .SCR_H(100), .SPR_W(100), .SPR_H(100), .STEP(7), .DIV(4)) u_edge (
        .clk(clk), .clrn(clrn), .run(run), .h_addr(h_addr), .v_addr(v_addr), .q(q),
        .rom_addr(e_rom), .vga_data(e_vga), .ph_addr(e_ph), .pv_addr(e_pv), .bounce_cnt(e_cnt)
    );

    sprite_bouncer #(.SCR_W(200), .SCR_H(200), .SPR_W(100), .SPR_H(100), .STEP(1), .DIV(4)) u_corner (
        .clk(clk), .clrn(clrn), .run(run), .h_addr(h_addr), .v_addr(v_addr), .q(q),
        .rom_addr(c_rom), .vga_data(c_vga), .ph_addr(c_ph), .pv_addr(c_pv), .bounce_cnt(c_cnt)
    );

    task automatic steps(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic run_after);
        @(negedge clk);
        clrn = 1'b0;
        run  = run_after;
        @(negedge clk);
        clrn = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        h_addr = 10'd700; v_addr = 10'd700;
        clrn = 1'b0; run = 1'b1;
        @(negedge clk);
        total++; if (m_ph !== 10'd0 || m_pv !== 10'd0) begin bad++; $display("FAIL reset_pos: got (%0d,%0d) expected (0,0)", m_ph, m_pv); end
        total++; if (m_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d expected 0", m_cnt); end
        total++; if (m_vga !== 24'h0 || m_rom !== 14'd0) begin bad++; $display("FAIL reset_pix: got vga=%h rom=%0d expected 0/0", m_vga, m_rom); end
        clrn = 1'b1;
        steps(7);
        total++; if (m_ph !== 10'd0 || m_pv !== 10'd0) begin bad++; $display("FAIL reset_early: got (%0d,%0d) expected (0,0)", m_ph, m_pv); end
        steps(1);
        total++; if (m_ph !== 10'd1 || m_pv !== 10'd1) begin bad++; $display("FAIL reset_first_tick: got (%0d,%0d) expected (1,1)", m_ph, m_pv); end
        // Reset part way through a period: the partial count must be dropped.
        steps(3);
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        steps(7);
        total++; if (m_ph !== 10'd0) begin bad++; $display("FAIL reset_mid_early: got %0d expected 0", m_ph); end
        steps(1);
        total++; if (m_ph !== 10'd1 || m_pv !== 10'd1) begin bad++; $display("FAIL reset_mid_tick: got (%0d,%0d) expected (1,1)", m_ph, m_pv); end
    endtask

    task automatic test_pixel;
        do_reset(1'b0);
        h_addr = 10'd100; v_addr = 10'd2; q = 12'hABC;
        steps(1);
        total++; if (m_rom !== 14'd0 || m_vga !== 24'h0) begin bad++; $display("FAIL pix_outside: got rom=%0d vga=%h expected 0/000000", m_rom, m_vga); end
        h_addr = 10'd5;
        steps(1);
        total++; if (m_rom !== 14'd205) begin bad++; $display("FAIL pix_rom_addr: got %0d expected 205", m_rom); end
        total++; if (m_vga !== 24'h0) begin bad++; $display("FAIL pix_latency1: got %h expected 000000", m_vga); end
        steps(1);
        total++; if (m_vga !== 24'hA0B0C0) begin bad++; $display("FAIL pix_data: got %h expected a0b0c0", m_vga); end
        h_addr = 10'd100;
        steps(1);
        total++; if (m_vga !== 24'hA0B0C0 || m_rom !== 14'd205) begin bad++; $display("FAIL pix_hold: got vga=%h rom=%0d expected a0b0c0/205", m_vga, m_rom); end
        steps(1);
        total++; if (m_vga !== 24'h0) begin bad++; $display("FAIL pix_exit: got %h expected 000000", m_vga); end
        h_addr = 10'd99; v_addr = 10'd99; q = 12'h123;
        steps(2);
        total++; if (m_rom !== 14'd9999 || m_vga !== 24'h102030) begin bad++; $display("FAIL pix_corner: got rom=%0d vga=%h expected 9999/102030", m_rom, m_vga); end
        v_addr = 10'd100;
        steps(2);
        total++; if (m_vga !== 24'h0) begin bad++; $display("FAIL pix_below: got %h expected 000000", m_vga); end
        h_addr = 10'd700; v_addr = 10'd700;
    endtask

    task automatic test_colorkey;
        do_reset(1'b0);
        h_addr = 10'd5; v_addr = 10'd2; q = 12'hF0F;
        steps(2);
`ifdef SPRITE_BOUNCER_COLORKEY_EN
        total++; if (m_vga !== 24'h0) begin bad++; $display("FAIL key_match: got %h expected 000000", m_vga); end
`else
        total++; if (m_vga !== 24'hF000F0) begin bad++; $display("FAIL key_off: got %h expected f000f0", m_vga); end
`endif
        q = 12'hF0E;
        steps(2);
        total++; if (m_vga !== 24'hF000E0) begin bad++; $display("FAIL key_nomatch: got %h expected f000e0", m_vga); end
        h_addr = 10'd700; v_addr = 10'd700;
    endtask

    task automatic test_pause;
        do_reset(1'b1);
        steps(8 + 3);
        total++; if (m_ph !== 10'd1) begin bad++; $display("FAIL pause_pre: got %0d expected 1", m_ph); end
        run = 1'b0;
        steps(1000);
        total++; if (m_ph !== 10'd1 || m_pv !== 10'd1) begin bad++; $display("FAIL pause_hold: got (%0d,%0d) expected (1,1)", m_ph, m_pv); end
        run = 1'b1;
        steps(4);
        total++; if (m_ph !== 10'd1) begin bad++; $display("FAIL pause_resume_early: got %0d expected 1", m_ph); end
        steps(1);
        total++; if (m_ph !== 10'd2 || m_pv !== 10'd2) begin bad++; $display("FAIL pause_resume_tick: got (%0d,%0d) expected (2,2)", m_ph, m_pv); end
    endtask

    task automatic test_edge;
        do_reset(1'b1);
        steps(77 * 4);
        total++; if (e_ph !== 10'd539 || e_cnt !== 16'd0) begin bad++; $display("FAIL edge_pre: got ph=%0d cnt=%0d expected 539/0", e_ph, e_cnt); end
        total++; if (e_pv !== 10'd0) begin bad++; $display("FAIL edge_ypinned: got %0d expected 0", e_pv); end
        steps(4);
        total++; if (e_ph !== 10'd540 || e_cnt !== 16'd1) begin bad++; $display("FAIL edge_clamp: got ph=%0d cnt=%0d expected 540/1", e_ph, e_cnt); end
        steps(4);
        total++; if (e_ph !== 10'd533 || e_cnt !== 16'd1) begin bad++; $display("FAIL edge_return: got ph=%0d cnt=%0d expected 533/1", e_ph, e_cnt); end
    endtask

    task automatic test_corner;
        do_reset(1'b1);
        steps(99 * 4);
        total++; if (c_ph !== 10'd99 || c_pv !== 10'd99 || c_cnt !== 16'd0) begin bad++; $display("FAIL corner_pre: got (%0d,%0d) cnt=%0d expected (99,99)/0", c_ph, c_pv, c_cnt); end
        steps(4);
        total++; if (c_ph !== 10'd100 || c_pv !== 10'd100 || c_cnt !== 16'd1) begin bad++; $display("FAIL corner_hit: got (%0d,%0d) cnt=%0d expected (100,100)/1", c_ph, c_pv, c_cnt); end
        steps(4);
        total++; if (c_ph !== 10'd99 || c_pv !== 10'd99 || c_cnt !== 16'd1) begin bad++; $display("FAIL corner_back: got (%0d,%0d) cnt=%0d expected (99,99)/1", c_ph, c_pv, c_cnt); end
    endtask

    initial begin
        test_reset();
        test_pixel();
        test_colorkey();
        test_pause();
        test_edge();
        test_corner();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
